// File: rtl/mod_n_updown_counter_pkg.sv
// Shared definitions for the modulo-N up/down counter: direction encodings,
// a constant clog2 helper and an elaboration-time parameter check.
`ifndef MOD_N_UPDOWN_COUNTER_PKG_SV
`define MOD_N_UPDOWN_COUNTER_PKG_SV

`define MNUD_PARAM_CHECK(label, cond, msg) if (!(cond)) begin : label $error(msg); end

package mod_n_updown_counter_pkg;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    // Smallest r with 2**r >= n; returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

`endif

// File: rtl/mod_n_updown_counter_if.sv
// Control/status bundle between a sequencer and the modulo-N counter.
interface mod_n_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             load_err;

    modport master (
        output en, up, clr, load, load_val,
        input  count, tc, wrap, load_err
    );

    modport slave (
        input  en, up, clr, load, load_val,
        output count, tc, wrap, load_err
    );
endinterface

// File: rtl/mod_n_updown_counter_tick_prescaler.sv
// Enable divider: tick_o pulses on every PRESCALE-th enabled cycle.
// With PRESCALE == 1 it reduces to a wire from en_i and holds no state.
module mod_n_updown_counter_tick_prescaler
    import mod_n_updown_counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk_i,
    input  logic res_i,
    input  logic en_i,
    input  logic sclr_i,
    output logic tick_o
);

    `MNUD_PARAM_CHECK(g_chk_prescale, PRESCALE >= 1, "PRESCALE must be at least 1")

    if (PRESCALE == 1) begin : g_bypass
        logic unused_ctrl;
        assign unused_ctrl = ^{clk_i, res_i, sclr_i};
        assign tick_o      = en_i;
    end else begin : g_div
        localparam int            PW   = clog2(PRESCALE);
        localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

        logic [PW-1:0] pre_q;
        logic [PW-1:0] pre_d;
        logic          at_last;

        assign at_last = (pre_q == LAST);

        // Phase only moves on enabled cycles, so gaps in en_i stretch the period.
        always_comb begin
            pre_d = pre_q;
            if (sclr_i) begin
                pre_d = '0;
            end else if (en_i) begin
                pre_d = at_last ? '0 : pre_q + 1'b1;
            end
        end

        always_ff @(posedge clk_i) begin
            if (res_i) begin
                pre_q <= '0;
            end else begin
                pre_q <= pre_d;
            end
        end

        assign tick_o = en_i & at_last;
    end

endmodule

// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter with prescaled enable, synchronous clear/load,
// load clamping and registered wrap / load-error pulses for cascading.
module mod_n_updown_counter
    import mod_n_updown_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 10,
    parameter int PRESCALE = 1
) (
    input  logic                   clk_i,
    input  logic                   res_i,
    mod_n_updown_counter_if.slave  cnt_if
);

    `MNUD_PARAM_CHECK(g_chk_modulus, MODULUS >= 2, "MODULUS must be at least 2")
    `MNUD_PARAM_CHECK(g_chk_width, MODULUS <= (1 << WIDTH), "WIDTH too small for MODULUS")

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             load_err_q;
    logic             load_err_d;
    logic             tick;

    mod_n_updown_counter_tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk_i  (clk_i),
        .res_i  (res_i),
        .en_i   (cnt_if.en),
        .sclr_i (cnt_if.clr | cnt_if.load),
        .tick_o (tick)
    );

    // Wrap is detected by explicit compare so power-of-two moduli never rely on overflow.
    always_comb begin
        count_d    = count_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (cnt_if.clr) begin
            count_d = '0;
        end else if (cnt_if.load) begin
            if (cnt_if.load_val > MAX_CNT) begin
                count_d    = MAX_CNT;
                load_err_d = 1'b1;
            end else begin
                count_d = cnt_if.load_val;
            end
        end else if (tick) begin
            if (cnt_if.up == DIR_UP) begin
                if (count_q == MAX_CNT) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    count_d = MAX_CNT;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (res_i) begin
            count_q    <= '0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign cnt_if.count    = count_q;
    assign cnt_if.wrap     = wrap_q;
    assign cnt_if.load_err = load_err_q;
    assign cnt_if.tc       = (cnt_if.up == DIR_DOWN) ? (count_q == '0) : (count_q == MAX_CNT);

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Directed + randomized bench: two counters (PRESCALE 1 and 3) share stimulus;
// a behavioural model pushes expectations to a queue checked after each edge.
module tb_mod_n_updown_counter;

    localparam int W = 4;
    localparam int M = 10;

    logic         clk = 1'b0;
    logic         res;
    logic         en;
    logic         up;
    logic         clr;
    logic         load;
    logic [W-1:0] lv;

    always #5 clk = ~clk;

    mod_n_updown_counter_if #(.WIDTH(W)) bus_a ();
    mod_n_updown_counter_if #(.WIDTH(W)) bus_b ();

    assign bus_a.en = en;   assign bus_a.up = up;   assign bus_a.clr = clr;
    assign bus_a.load = load; assign bus_a.load_val = lv;
    assign bus_b.en = en;   assign bus_b.up = up;   assign bus_b.clr = clr;
    assign bus_b.load = load; assign bus_b.load_val = lv;

    mod_n_updown_counter #(.WIDTH(W), .MODULUS(M), .PRESCALE(1)) dut_a (
        .clk_i (clk), .res_i (res), .cnt_if (bus_a)
    );
    mod_n_updown_counter #(.WIDTH(W), .MODULUS(M), .PRESCALE(3)) dut_b (
        .clk_i (clk), .res_i (res), .cnt_if (bus_b)
    );

    typedef struct {
        int           idx;
        logic [W-1:0] cnt;
        logic         wrap;
        logic         err;
    } exp_t;

    exp_t exp_q[$];
    int   m_cnt [2];
    int   m_pre [2];
    int   ps    [2] = '{1, 3};
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic cycle(input string tag);
        exp_t         e;
        logic         w;
        logic         er;
        logic [W-1:0] o_cnt;
        logic         o_wrap;
        logic         o_err;
        logic         o_tc;
        string        nm;
        for (int i = 0; i < 2; i++) begin
            w  = 1'b0;
            er = 1'b0;
            if (res) begin
                m_cnt[i] = 0;
                m_pre[i] = 0;
            end else if (clr) begin
                m_cnt[i] = 0;
                m_pre[i] = 0;
            end else if (load) begin
                m_pre[i] = 0;
                if (int'(lv) >= M) begin
                    m_cnt[i] = M - 1;
                    er       = 1'b1;
                end else begin
                    m_cnt[i] = int'(lv);
                end
            end else if (en) begin
                if (m_pre[i] == ps[i] - 1) begin
                    m_pre[i] = 0;
                    if (up) begin
                        m_cnt[i] = (m_cnt[i] + 1) % M;
                        w        = (m_cnt[i] == 0);
                    end else begin
                        w        = (m_cnt[i] == 0);
                        m_cnt[i] = (m_cnt[i] + M - 1) % M;
                    end
                end else begin
                    m_pre[i] = m_pre[i] + 1;
                end
            end
            e.idx  = i;
            e.cnt  = W'(m_cnt[i]);
            e.wrap = w;
            e.err  = er;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.idx == 0) begin
                o_cnt = bus_a.count; o_wrap = bus_a.wrap; o_err = bus_a.load_err; o_tc = bus_a.tc;
                nm = {tag, "/p1"};
            end else begin
                o_cnt = bus_b.count; o_wrap = bus_b.wrap; o_err = bus_b.load_err; o_tc = bus_b.tc;
                nm = {tag, "/p3"};
            end
            chk({nm, ".count"}, 32'(o_cnt), 32'(e.cnt));
            chk({nm, ".wrap"}, 32'(o_wrap), 32'(e.wrap));
            chk({nm, ".load_err"}, 32'(o_err), 32'(e.err));
            chk({nm, ".tc"}, 32'(o_tc), up ? 32'(e.cnt == W'(M - 1)) : 32'(e.cnt == '0));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res = 1'b1; en = 1'b1; up = 1'b1; clr = 1'b0; load = 1'b0; lv = '0;
        m_cnt = '{0, 0};
        m_pre = '{0, 0};

        // reset held two cycles, then release
        cycle("rst0");
        cycle("rst1");
        chk("reset_count", 32'(bus_a.count), 0);
        chk("reset_wrap", 32'(bus_a.wrap), 0);
        chk("reset_lerr", 32'(bus_a.load_err), 0);
        res = 1'b0;
        cycle("release");
        chk("release_count", 32'(bus_a.count), 1);

        // up wrap
        for (int k = 0; k < 8; k++) cycle("up");
        chk("up_at_max", 32'(bus_a.count), 9);
        chk("up_tc_at_max", 32'(bus_a.tc), 1);
        cycle("up_wrap");
        chk("up_wrap_count", 32'(bus_a.count), 0);
        chk("up_wrap_pulse", 32'(bus_a.wrap), 1);
        cycle("up_after");
        chk("up_wrap_drop", 32'(bus_a.wrap), 0);

        // down wrap
        load = 1'b1; lv = 4'd2; up = 1'b0;
        cycle("load2");
        chk("load2_count", 32'(bus_a.count), 2);
        load = 1'b0;
        cycle("dn");
        chk("dn_count1", 32'(bus_a.count), 1);
        cycle("dn");
        chk("dn_count0", 32'(bus_a.count), 0);
        chk("dn_tc0", 32'(bus_a.tc), 1);
        cycle("dn_wrap");
        chk("dn_wrap_count", 32'(bus_a.count), 9);
        chk("dn_wrap_pulse", 32'(bus_a.wrap), 1);
        chk("dn_tc_at9", 32'(bus_a.tc), 0);

        // tc follows direction without a clock edge
        up = 1'b1; #1;
        chk("tc_toggle_up", 32'(bus_a.tc), 1);
        up = 1'b0; #1;
        chk("tc_toggle_dn", 32'(bus_a.tc), 0);

        // load clamp
        en = 1'b0; load = 1'b1; lv = 4'd13;
        cycle("clamp");
        chk("clamp_count", 32'(bus_a.count), 9);
        chk("clamp_err", 32'(bus_a.load_err), 1);
        load = 1'b0;
        cycle("clamp_after");
        chk("clamp_err_drop", 32'(bus_a.load_err), 0);
        load = 1'b1; lv = 4'd5;
        cycle("load5");
        chk("load5_count", 32'(bus_a.count), 5);
        chk("load5_err", 32'(bus_a.load_err), 0);

        // priority
        lv = 4'd7;
        cycle("load7");
        clr = 1'b1; load = 1'b1; en = 1'b1; lv = 4'd3;
        cycle("clr_over_load");
        chk("clr_prio_count", 32'(bus_a.count), 0);
        clr = 1'b0; load = 1'b1; en = 1'b0; lv = 4'd8;
        cycle("load8");
        res = 1'b1; clr = 1'b1; load = 1'b1; en = 1'b1; lv = 4'd13;
        cycle("res_over_all");
        chk("res_prio_count", 32'(bus_a.count), 0);
        chk("res_prio_lerr", 32'(bus_a.load_err), 0);
        chk("res_prio_wrap", 32'(bus_a.wrap), 0);
        res = 1'b0; load = 1'b0;

        // prescale 3 spacing
        cycle("ps_clr");
        clr = 1'b0; en = 1'b1; up = 1'b1;
        cycle("ps");
        cycle("ps");
        chk("ps_hold", 32'(bus_b.count), 0);
        cycle("ps");
        chk("ps_step3", 32'(bus_b.count), 1);
        cycle("ps");
        en = 1'b0;
        cycle("ps_gap");
        cycle("ps_gap");
        en = 1'b1;
        cycle("ps");
        chk("ps_gap_hold", 32'(bus_b.count), 1);
        cycle("ps");
        chk("ps_gap_step", 32'(bus_b.count), 2);
        cycle("ps");
        load = 1'b1; lv = 4'd4;
        cycle("ps_load");
        load = 1'b0;
        cycle("ps");
        cycle("ps");
        chk("ps_load_hold", 32'(bus_b.count), 4);
        cycle("ps");
        chk("ps_load_step", 32'(bus_b.count), 5);

        // randomized traffic
        for (int k = 0; k < 80; k++) begin
            res  = ($urandom_range(0, 24) == 0);
            clr  = ($urandom_range(0, 14) == 0);
            load = ($urandom_range(0, 7) == 0);
            lv   = W'($urandom_range(0, 15));
            en   = ($urandom_range(0, 3) != 0);
            up   = ($urandom_range(0, 2) != 0);
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
